pmem_responder: RTL
===================

# pmem_responder

Physical-memory responder on the cache-to-main-memory port. Accepts line-granular (128-bit) read and write requests from the cache controller/datapath, holds them for a configurable latency, and completes each with a single-cycle `pmem_resp` pulse. Used as the memory-side model under the two-way cache, and as the template for the real memory controller.

## Interface
Parameters:
- `LATENCY`, 4, cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `LINES`, 4096, number of 16-byte lines; 4096 covers the full 16-bit address space.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  line read request; held until `pmem_resp`.
- `pmem_write`  in  1  line write request; held until `pmem_resp`.
- `pmem_address`  in  16  byte address (`lc3b_word`); bits [3:0] ignored; line index = `[15:4]`.
- `pmem_wdata`  in  128  write line.
- `pmem_rdata`  out  128  read line; valid in the `pmem_resp` cycle of a read.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `protocol_err`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - On a clock edge with exactly one of `pmem_read`/`pmem_write` high:
    - latch op, `pmem_address[15:4]` and `pmem_wdata`;
    - load the down-counter with `LATENCY-1`;
    - go to BUSY, or directly to RESP if `LATENCY==1`.
  - Both requests high: treated as a read. Also a protocol error.
- **BUSY**
  - Counter decrements each cycle. Go to RESP when it reaches 0.
  - Abort rule: if both requests are low at an edge in BUSY, return to IDLE. No response is issued and memory is unchanged.
- **RESP**
  - `pmem_resp`=1 for exactly one cycle, then IDLE.
  - Read: `pmem_rdata` = stored line at the latched index.
  - Write: the latched `pmem_wdata` is committed to the line store at the edge ending RESP.
- Only latched values are used. Address or wdata changes after acceptance do not affect the transaction.
- Back-to-back requests: a request still high in the cycle after RESP is accepted as a new transaction. The requester must drop its request on seeing `pmem_resp`.
- `pmem_rdata` holds its last read value outside RESP. Writes do not change it.
- Addresses with index ≥ `LINES` wrap modulo `LINES`.

## Timing
- Request first high in cycle t (FSM in IDLE): accepted at the end of t; `pmem_resp` high in cycle t+`LATENCY`.
- Write data becomes visible to a read accepted at or after cycle t+`LATENCY`+1.
- Read-after-write to the same line, back to back: the read returns the new data.
- Reset asserted (async, any state):
  - FSM → IDLE, counter → 0, `pmem_resp`=0, `pmem_rdata`=0, `protocol_err`=0.
  - Line store contents are not cleared.
  - An in-flight write is dropped.
- Outputs are registered. No combinational path from inputs to `pmem_resp` or `pmem_rdata`.

## Configuration
- `PMEM_PROTOCOL_CHECK_EN` defined: `protocol_err` is set and held until reset on any of:
  - both requests high in any cycle;
  - `pmem_address[15:4]` changes while BUSY with a request held;
  - op switches read↔write while BUSY.
- Not defined: `protocol_err` is tied 0 and the checker logic is absent. Functional behaviour is identical either way.

## Structure
- Add to `lc3b_types`:
  - `lc3b_line` (128-bit);
  - `lc3b_line_index` (12-bit);
  - `pmem_state_t` enum {IDLE, BUSY, RESP}.
- One sub-module, `line_store`: `LINES`×128 array, synchronous write, combinational read by index.
- FSM, counter and checker live in `pmem_responder`.

## Test plan
- Reset, then write 0x0123…CDEF to 0x1230 with `LATENCY`=4 → `pmem_resp` exactly in cycle t+4, one cycle wide. A following read of 0x123A returns the same line.
- Read an unwritten line after write/read traffic → returns the preserved store value, unaffected by reset.
- Accept a read of 0x0040, change the address to 0x0080 in BUSY → data is from line 0x004. With the macro defined, `protocol_err`=1.
- Accept a write, drop both requests in cycle t+2 → no `pmem_resp`; a subsequent read shows old data.
- Assert `reset_n`=0 mid-write in cycle t+3 → `pmem_resp` never asserts, the line is unchanged, and all outputs return to reset values asynchronously.
- `LATENCY`=1, back-to-back read then write held continuously → two responses at t+1 and t+3.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, extended with the line-granular memory-port types.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_index;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
endpackage

// File: rtl/pmem_responder_line_store.sv
// LINES x 128-bit line array: synchronous write, combinational read by index.
module line_store
  import lc3b_types::*;
#(
  parameter int LINES = 4096
) (
  input  logic         clk,
  input  logic         we,
  input  logic [11:0]  widx,
  input  logic [127:0] wdata,
  input  logic [11:0]  ridx,
  output logic [127:0] rdata
);
  localparam int AW = $clog2(LINES);

  // No reset: contents must survive reset of the responder.
  lc3b_line mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[widx[AW-1:0]] <= wdata;
  end

  assign rdata = mem[ridx[AW-1:0]];
endmodule

// File: rtl/pmem_responder.sv
// Line-granular memory responder: completes each request after LATENCY cycles with a one-cycle pulse.
// Define PMEM_PROTOCOL_CHECK_EN to build the sticky protocol_err checker; otherwise protocol_err is 0.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         protocol_err
);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_state_t    state, state_n;
  logic [7:0]     cnt, cnt_n;
  logic           op_wr;
  lc3b_line_index idx;
  lc3b_line       wdata_q;
  lc3b_line       store_rdata;
  lc3b_line_index ridx;
  logic           req, new_op_wr, accept, load_rdata, store_we;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^pmem_address[3:0];
  assign req       = pmem_read | pmem_write;
  assign new_op_wr = pmem_write & ~pmem_read;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_n   = LAT_M1;
          state_n = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY==1 the read line is fetched in the accept cycle, before idx is latched.
  assign ridx       = (state == IDLE) ? pmem_address[15:4] : idx;
  assign load_rdata = (state_n == RESP) && ((state == IDLE) ? !new_op_wr : !op_wr);
  assign store_we   = (state == RESP) && op_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pmem_resp <= (state_n == RESP);
      if (accept) begin
        op_wr   <= new_op_wr;
        idx     <= pmem_address[15:4];
        wdata_q <= pmem_wdata;
      end
      if (load_rdata) pmem_rdata <= store_rdata;
    end
  end

  line_store #(.LINES(LINES)) u_store (
    .clk   (clk),
    .we    (store_we),
    .widx  (idx),
    .wdata (wdata_q),
    .ridx  (ridx),
    .rdata (store_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic perr_set;

  always_comb begin
    perr_set = (pmem_read && pmem_write) ||
               ((state == BUSY) && req &&
                ((pmem_address[15:4] != idx) ||
                 (op_wr ? (pmem_read && !pmem_write) : (pmem_write && !pmem_read))));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      protocol_err <= 1'b0;
    else if (perr_set) protocol_err <= 1'b1;
  end
`else
  assign protocol_err = 1'b0;
`endif
endmodule
